neopix_frame_sched: RTL and testbench
=====================================

NEOPIX_FRAME_SCHED -- requirements
Module: neopix_frame_sched

Interface
REQ-001 Parameter NUM_LEDS, default 256, LEDs per frame bank.
REQ-002 Parameter LATCH_CYC, default 15000, CLK cycles of line-low latch gap after each frame (300 us at 50 MHz).
REQ-003 Parameter REFRESH_CYC, default 1000000, CLK cycles between periodic re-sends (20 ms at 50 MHz).
REQ-004 CLK  in  1  single system clock; all logic on its rising edge.
REQ-005 RST_N  in  1  reset, asynchronous assert, active-low.
REQ-006 FRAME_DONE  in  1  one-cycle pulse: the SPI writer finished a frame into bank WR_BANK.
REQ-007 WR_COUNT  in  clog2(NUM_LEDS)+1  LED count of that frame, valid with FRAME_DONE.
REQ-008 TX_DONE  in  1  one-cycle pulse: the serializer finished shifting the last LED.
REQ-009 TX_START  out  1  one-cycle pulse: the serializer begins a frame from DISP_BANK.
REQ-010 DISP_BANK  out  1  RAM bank read by the serializer.
REQ-011 WR_BANK  out  1  RAM bank written by the SPI writer; always ~DISP_BANK.
REQ-012 DISP_COUNT  out  clog2(NUM_LEDS)+1  valid LEDs in DISP_BANK; the serializer blanks addresses at or above it.
REQ-013 SWAP_PENDING  out  1  a completed frame is waiting to be displayed.
REQ-014 OVERRUN  out  1  sticky: a completed frame was overwritten before it was displayed.
REQ-015 FRAME_CNT  out  16  number of frames started, wrapping.

Function
REQ-016 FSM states: IDLE, START, SEND, LATCH.
REQ-017 pend_next = SWAP_PENDING | FRAME_DONE; cnt_next = WR_COUNT if FRAME_DONE, else the stored pending count.
REQ-018 IDLE: if pend_next, then in one edge toggle DISP_BANK/WR_BANK, load DISP_COUNT from cnt_next, clear SWAP_PENDING, and go to START.
REQ-019 START: TX_START=1 for exactly one cycle; FRAME_CNT increments; next state SEND.
REQ-020 SEND: hold until TX_DONE; then load the latch counter with LATCH_CYC-1 and go to LATCH.
REQ-021 LATCH: decrement the counter; when it reaches 0, apply the IDLE rule of REQ-018; if nothing is pending, go to IDLE.
REQ-022 A bank swap occurs only in IDLE or at latch expiry; never in START or SEND.
REQ-023 FRAME_DONE in any state other than a swapping cycle sets SWAP_PENDING and stores WR_COUNT.
REQ-024 FRAME_DONE while SWAP_PENDING=1 sets OVERRUN; the newest WR_COUNT replaces the stored count.
REQ-025 FRAME_DONE in a swapping cycle is consumed by that swap; SWAP_PENDING stays 0.
REQ-026 TX_DONE outside SEND is ignored.
REQ-027 Latency: from FRAME_DONE in IDLE to TX_START is 2 cycles (swap edge, then the START cycle).
REQ-028 Minimum spacing between TX_START pulses is (TX_DONE arrival) + LATCH_CYC + 1 cycles.
REQ-029 WR_COUNT values above NUM_LEDS are clamped to NUM_LEDS.

Reset
REQ-030 When RST_N=0: state=IDLE, DISP_BANK=0, WR_BANK=1, DISP_COUNT=0, TX_START=0, SWAP_PENDING=0, OVERRUN=0, FRAME_CNT=0, and all counters=0.
REQ-031 Reset mid-SEND or mid-LATCH aborts with no TX_START after release until a new FRAME_DONE arrives.
REQ-032 Reset release is used synchronously; the first active edge after deassertion follows the normal FSM.

Configuration
REQ-033 Macro NEOPIX_SCHED_REFRESH_EN.
- Defined: a refresh timer reloads REFRESH_CYC-1 on every TX_START and counts down to 0. With the timer at 0 and nothing pending, IDLE goes to START without a swap, re-sending DISP_BANK with unchanged DISP_COUNT. A pending frame takes precedence over refresh.
- Undefined: no timer is built, and frames are sent only on a swap.

Verification
REQ-034 Reset, then FRAME_DONE with WR_COUNT=10 in IDLE -> next edge DISP_BANK=1 and DISP_COUNT=10; TX_START on cycle 2; FRAME_CNT=1.
REQ-035 FRAME_DONE (WR_COUNT=5) during SEND, with TX_DONE at t -> SWAP_PENDING=1 until latch expiry at t+LATCH_CYC; then swap to DISP_BANK=0, DISP_COUNT=5, and one TX_START.
REQ-036 Two FRAME_DONE pulses (counts 7, then 9) during one SEND -> OVERRUN=1; the next displayed DISP_COUNT=9; exactly one swap.
REQ-037 FRAME_DONE in the same cycle as latch expiry with a pending frame -> one swap, SWAP_PENDING=0 afterwards, no OVERRUN.
REQ-038 RST_N low for 1 cycle mid-LATCH -> all outputs at reset values; no TX_START until FRAME_DONE.
REQ-039 With NEOPIX_SCHED_REFRESH_EN, REFRESH_CYC=100, LATCH_CYC=10, TX_DONE 20 cycles after TX_START, no FRAME_DONE -> TX_START every 100 cycles, DISP_BANK unchanged; without the macro -> no second TX_START.

Source files
------------

// File: rtl/neopix_frame_sched_if.sv
// ---------------------------------------------------------------------------
// neopix_frame_sched_if
//   Connects the NeoPixel frame scheduler to its SPI frame writer and its
//   LED serializer.
//
//   Writer side  : FRAME_DONE, WR_COUNT   (frame landed in bank WR_BANK)
//   Serializer   : TX_DONE                (last LED shifted out)
//   Scheduler    : TX_START, DISP_BANK, WR_BANK, DISP_COUNT,
//                  SWAP_PENDING, OVERRUN, FRAME_CNT
//
//   modport master : the scheduler itself
//   modport slave  : the writer/serializer side (or a testbench)
// ---------------------------------------------------------------------------
interface neopix_frame_sched_if #(
    parameter int NUM_LEDS = 256
);
    localparam int CNT_W = $clog2(NUM_LEDS) + 1;

    logic             FRAME_DONE;
    logic [CNT_W-1:0] WR_COUNT;
    logic             TX_DONE;
    logic             TX_START;
    logic             DISP_BANK;
    logic             WR_BANK;
    logic [CNT_W-1:0] DISP_COUNT;
    logic             SWAP_PENDING;
    logic             OVERRUN;
    logic [15:0]      FRAME_CNT;

    modport master (
        input  FRAME_DONE, WR_COUNT, TX_DONE,
        output TX_START, DISP_BANK, WR_BANK, DISP_COUNT,
               SWAP_PENDING, OVERRUN, FRAME_CNT
    );

    modport slave (
        output FRAME_DONE, WR_COUNT, TX_DONE,
        input  TX_START, DISP_BANK, WR_BANK, DISP_COUNT,
               SWAP_PENDING, OVERRUN, FRAME_CNT
    );
endinterface

// File: rtl/neopix_frame_sched.sv
// ---------------------------------------------------------------------------
// neopix_frame_sched
//   Double-buffered frame scheduler for a NeoPixel (WS281x) string. The SPI
//   writer fills one RAM bank while the serializer streams the other. The
//   scheduler swaps banks only when the line is idle or the latch gap has
//   just expired, so a frame is never torn mid-transmission.
//
//   Ports
//     CLK    : system clock, rising edge
//     RST_N  : asynchronous active-low reset
//     bus    : neopix_frame_sched_if.master
//              in : FRAME_DONE, WR_COUNT, TX_DONE
//              out: TX_START, DISP_BANK, WR_BANK, DISP_COUNT,
//                   SWAP_PENDING, OVERRUN, FRAME_CNT
//
//   Parameters
//     NUM_LEDS    : LEDs per frame bank
//     LATCH_CYC   : line-low latch gap after each frame, in CLK cycles
//     REFRESH_CYC : period of unsolicited re-sends (refresh build only)
//
//   Build option
//     NEOPIX_SCHED_REFRESH_EN : when defined, the displayed bank is re-sent
//     every REFRESH_CYC cycles while no new frame arrives. Undefined, frames
//     go out only on a bank swap.
// ---------------------------------------------------------------------------
module neopix_frame_sched #(
    parameter int NUM_LEDS    = 256,
    parameter int LATCH_CYC   = 15000,
    parameter int REFRESH_CYC = 1000000
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    neopix_frame_sched_if.master bus
);
    localparam int CNT_W = $clog2(NUM_LEDS) + 1;
    localparam int LAT_W = $clog2(LATCH_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_SEND,
        S_LATCH
    } state_t;

    state_t           state;
    logic [LAT_W-1:0] lat_cnt;
    logic [CNT_W-1:0] pend_cnt;
    logic             tx_start;
    logic             disp_bank;
    logic [CNT_W-1:0] disp_count;
    logic             swap_pending;
    logic             overrun;
    logic [15:0]      frame_cnt;

    logic             pend_next;
    logic [CNT_W-1:0] cnt_next;
    logic             lat_exp;
    logic             swap_go;
    logic             refresh_go;
    logic             start_go;

    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] c);
        if (c > CNT_W'(NUM_LEDS))
            return CNT_W'(NUM_LEDS);
        return c;
    endfunction

    assign pend_next = swap_pending | bus.FRAME_DONE;
    assign cnt_next  = bus.FRAME_DONE ? clamp_count(bus.WR_COUNT) : pend_cnt;
    assign lat_exp   = (state == S_LATCH) && (lat_cnt == '0);
    // A swap happens only with the line idle or right at latch expiry; a
    // FRAME_DONE arriving in that same cycle is folded into the swap.
    assign swap_go   = pend_next && ((state == S_IDLE) || lat_exp);
    assign start_go  = swap_go | refresh_go;

`ifdef NEOPIX_SCHED_REFRESH_EN
    localparam int REF_W = $clog2(REFRESH_CYC + 1);
    logic [REF_W-1:0] ref_cnt;
    // The timer sits at zero out of reset; refresh stays disarmed until a
    // real frame has been shown, so reset never triggers a spurious send.
    logic             ref_armed;

    assign refresh_go = (state == S_IDLE) && !pend_next && ref_armed && (ref_cnt == '0);
`else
    logic unused_refresh_cfg;

    assign refresh_go         = 1'b0;
    assign unused_refresh_cfg = (REFRESH_CYC > 0);
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= S_IDLE;
            lat_cnt      <= '0;
            pend_cnt     <= '0;
            tx_start     <= 1'b0;
            disp_bank    <= 1'b0;
            disp_count   <= '0;
            swap_pending <= 1'b0;
            overrun      <= 1'b0;
            frame_cnt    <= '0;
`ifdef NEOPIX_SCHED_REFRESH_EN
            ref_cnt      <= '0;
            ref_armed    <= 1'b0;
`endif
        end else begin
            // Bank bookkeeping
            if (swap_go) begin
                disp_bank    <= ~disp_bank;
                disp_count   <= cnt_next;
                swap_pending <= 1'b0;
            end else if (bus.FRAME_DONE) begin
                swap_pending <= 1'b1;
                pend_cnt     <= clamp_count(bus.WR_COUNT);
                if (swap_pending)
                    overrun <= 1'b1;
            end

            // TX_START is registered: it is high for the single cycle spent in START
            tx_start <= start_go;
            if (start_go)
                frame_cnt <= frame_cnt + 16'd1;

            case (state)
                S_IDLE: begin
                    if (start_go)
                        state <= S_START;
                end
                S_START: begin
                    state <= S_SEND;
                end
                S_SEND: begin
                    if (bus.TX_DONE) begin
                        lat_cnt <= LAT_W'(LATCH_CYC - 1);
                        state   <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    if (lat_cnt == '0)
                        state <= swap_go ? S_START : S_IDLE;
                    else
                        lat_cnt <= lat_cnt - LAT_W'(1);
                end
                default: state <= S_IDLE;
            endcase

`ifdef NEOPIX_SCHED_REFRESH_EN
            if (swap_go)
                ref_armed <= 1'b1;
            if (start_go)
                ref_cnt <= REF_W'(REFRESH_CYC - 1);
            else if (ref_cnt != '0)
                ref_cnt <= ref_cnt - REF_W'(1);
`endif
        end
    end

    assign bus.TX_START     = tx_start;
    assign bus.DISP_BANK    = disp_bank;
    assign bus.WR_BANK      = ~disp_bank;
    assign bus.DISP_COUNT   = disp_count;
    assign bus.SWAP_PENDING = swap_pending;
    assign bus.OVERRUN      = overrun;
    assign bus.FRAME_CNT    = frame_cnt;

endmodule

// File: tb/tb_neopix_frame_sched.sv
// ---------------------------------------------------------------------------
// tb_neopix_frame_sched
//   Bench for neopix_frame_sched (default build, refresh disabled) with
//   NUM_LEDS=16, LATCH_CYC=10, REFRESH_CYC=100. A cycle table drives
//   FRAME_DONE/WR_COUNT/TX_DONE and lists the outputs expected after each
//   edge; every expected TX_START also queues its bank/count/frame number
//   so each pulse the DUT emits is matched against the queue.
// ---------------------------------------------------------------------------
module tb_neopix_frame_sched;
    localparam int NUM_LEDS    = 16;
    localparam int LATCH_CYC   = 10;
    localparam int REFRESH_CYC = 100;
    localparam int CNT_W       = $clog2(NUM_LEDS) + 1;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    always #5 CLK = ~CLK;

    neopix_frame_sched_if #(.NUM_LEDS(NUM_LEDS)) bus ();

    neopix_frame_sched #(
        .NUM_LEDS   (NUM_LEDS),
        .LATCH_CYC  (LATCH_CYC),
        .REFRESH_CYC(REFRESH_CYC)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    typedef struct {
        logic             fd;
        logic [CNT_W-1:0] wc;
        logic             td;
        logic             tx;
        logic             bank;
        logic [CNT_W-1:0] cnt;
        logic             sp;
        logic             ov;
        logic [15:0]      fc;
    } vec_t;

    typedef struct {
        logic             bank;
        logic [CNT_W-1:0] cnt;
        logic [15:0]      fc;
    } start_t;

    vec_t   tbl[$];
    start_t sb[$];
    int     total = 0;
    int     bad   = 0;
    int     starts_seen = 0;

    task automatic add(input logic fd, input int wc, input logic td,
                       input logic tx, input logic bank, input int cnt,
                       input logic sp, input logic ov, input int fc);
        vec_t v;
        v.fd = fd; v.wc = CNT_W'(wc); v.td = td;
        v.tx = tx; v.bank = bank; v.cnt = CNT_W'(cnt);
        v.sp = sp; v.ov = ov; v.fc = 16'(fc);
        tbl.push_back(v);
    endtask

    // n idle rows with the outputs held at the given values
    task automatic hold(input int n, input logic bank, input int cnt,
                        input logic sp, input logic ov, input int fc);
        for (int k = 0; k < n; k++)
            add(1'b0, 0, 1'b0, 1'b0, bank, cnt, sp, ov, fc);
    endtask

    task automatic drive(input logic fd, input int wc, input logic td);
        bus.FRAME_DONE = fd;
        bus.WR_COUNT   = CNT_W'(wc);
        bus.TX_DONE    = td;
    endtask

    // Advance one edge, sample 1 time unit later, and match any TX_START
    // against the scoreboard.
    task automatic tick();
        start_t e;
        @(posedge CLK);
        #1;
        if (bus.TX_START === 1'b1) begin
            starts_seen++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_start: got tx_start bank=%0d cnt=%0d fc=%0d, required no tx_start",
                         bus.DISP_BANK, bus.DISP_COUNT, bus.FRAME_CNT);
            end else begin
                e = sb.pop_front();
                if ({bus.DISP_BANK, bus.DISP_COUNT, bus.FRAME_CNT} !== {e.bank, e.cnt, e.fc}) begin
                    bad++;
                    $display("FAIL sb_start: got bank=%0d cnt=%0d fc=%0d, required bank=%0d cnt=%0d fc=%0d",
                             bus.DISP_BANK, bus.DISP_COUNT, bus.FRAME_CNT, e.bank, e.cnt, e.fc);
                end
            end
        end
    endtask

    task automatic check_reset(input string name);
        logic [25:0] got;
        got = {bus.TX_START, bus.DISP_BANK, bus.WR_BANK, bus.DISP_COUNT,
               bus.SWAP_PENDING, bus.OVERRUN, bus.FRAME_CNT};
        total++;
        if (got !== {1'b0, 1'b0, 1'b1, CNT_W'(0), 1'b0, 1'b0, 16'd0}) begin
            bad++;
            $display("FAIL %s: got tx=%b bank=%b wr=%b cnt=%0d sp=%b ov=%b fc=%0d, required reset values",
                     name, bus.TX_START, bus.DISP_BANK, bus.WR_BANK, bus.DISP_COUNT,
                     bus.SWAP_PENDING, bus.OVERRUN, bus.FRAME_CNT);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    initial begin
        logic [25:0] got;
        logic [25:0] exp;
        int          base;

        drive(1'b0, 0, 1'b0);

        // Cycle table: inputs for the edge, outputs expected after it.
        // fd wc td | tx bank cnt sp ov fc
        add(0,  0, 0,  0, 0,  0, 0, 0, 0);   // idle after reset
        add(1, 10, 0,  1, 1, 10, 0, 0, 1);   // FRAME_DONE in IDLE: swap, START
        add(0,  0, 0,  0, 1, 10, 0, 0, 1);   // SEND
        add(1, 20, 0,  0, 1, 10, 1, 0, 1);   // frame in SEND, 20 clamps to 16
        add(0,  0, 1,  0, 1, 10, 1, 0, 1);   // TX_DONE -> LATCH
        hold(LATCH_CYC - 1, 1, 10, 1, 0, 1);
        add(0,  0, 0,  1, 0, 16, 0, 0, 2);   // latch expiry: swap to pending
        add(0,  0, 1,  0, 0, 16, 0, 0, 2);   // TX_DONE in START ignored
        add(0,  0, 0,  0, 0, 16, 0, 0, 2);   // SEND
        add(1,  3, 0,  0, 0, 16, 1, 0, 2);   // pending count 3
        add(0,  0, 1,  0, 0, 16, 1, 0, 2);   // LATCH
        hold(LATCH_CYC - 1, 0, 16, 1, 0, 2);
        add(1, 12, 0,  1, 1, 12, 0, 0, 3);   // FRAME_DONE at expiry: one swap, newest count
        add(0,  0, 0,  0, 1, 12, 0, 0, 3);   // SEND
        add(1,  7, 0,  0, 1, 12, 1, 0, 3);   // first frame in SEND
        add(1,  9, 0,  0, 1, 12, 1, 1, 3);   // second frame: OVERRUN
        add(0,  0, 1,  0, 1, 12, 1, 1, 3);   // LATCH
        hold(LATCH_CYC - 1, 1, 12, 1, 1, 3);
        add(0,  0, 0,  1, 0,  9, 0, 1, 4);   // single swap to the newest count
        add(0,  0, 0,  0, 0,  9, 0, 1, 4);   // SEND
        add(0,  0, 1,  0, 0,  9, 0, 1, 4);   // LATCH, nothing pending
        hold(LATCH_CYC - 1, 0, 9, 0, 1, 4);
        add(0,  0, 0,  0, 0,  9, 0, 1, 4);   // expiry -> IDLE, no send
        add(0,  0, 1,  0, 0,  9, 0, 1, 4);   // TX_DONE in IDLE ignored
        add(0,  0, 0,  0, 0,  9, 0, 1, 4);
        add(1, 16, 0,  1, 1, 16, 0, 1, 5);   // count exactly NUM_LEDS passes through
        add(0,  0, 0,  0, 1, 16, 0, 1, 5);   // SEND
        add(0,  0, 1,  0, 1, 16, 0, 1, 5);   // LATCH
        hold(LATCH_CYC - 1, 1, 16, 0, 1, 5);
        add(0,  0, 0,  0, 1, 16, 0, 1, 5);   // expiry -> IDLE

        // Reset
        repeat (3) @(posedge CLK);
        #1;
        check_reset("reset_state");
        RST_N = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].fd, int'(tbl[i].wc), tbl[i].td);
            if (tbl[i].tx)
                sb.push_back('{tbl[i].bank, tbl[i].cnt, tbl[i].fc});
            tick();
            got = {bus.TX_START, bus.DISP_BANK, bus.WR_BANK, bus.DISP_COUNT,
                   bus.SWAP_PENDING, bus.OVERRUN, bus.FRAME_CNT};
            exp = {tbl[i].tx, tbl[i].bank, ~tbl[i].bank, tbl[i].cnt,
                   tbl[i].sp, tbl[i].ov, tbl[i].fc};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL row_%0d: got tx=%b bank=%b wr=%b cnt=%0d sp=%b ov=%b fc=%0d, required tx=%b bank=%b wr=%b cnt=%0d sp=%b ov=%b fc=%0d",
                         i, got[25], got[24], got[23], got[22:18], got[17], got[16], got[15:0],
                         exp[25], exp[24], exp[23], exp[22:18], exp[17], exp[16], exp[15:0]);
            end
        end
        drive(1'b0, 0, 1'b0);

        // Reset pulse in the middle of LATCH, with another frame pending
        drive(1'b1, 4, 1'b0);
        sb.push_back('{1'b0, CNT_W'(4), 16'd6});
        tick();
        drive(1'b0, 0, 1'b0);
        tick();                                  // SEND
        drive(1'b1, 8, 1'b0);
        tick();                                  // pending frame
        check_int("pending_before_reset", int'(bus.SWAP_PENDING), 1);
        drive(1'b0, 0, 1'b1);
        tick();                                  // LATCH
        drive(1'b0, 0, 1'b0);
        repeat (4) tick();
        #2;
        RST_N = 1'b0;
        #1;
        check_reset("reset_async_assert");
        tick();
        check_reset("reset_mid_latch");
        RST_N = 1'b1;

        base = starts_seen;
        repeat (3 * LATCH_CYC) tick();
        check_int("no_start_after_reset", starts_seen - base, 0);
        check_reset("idle_after_reset");

        // New frame after reset, then the refresh scenario for the default build
        drive(1'b1, 6, 1'b0);
        sb.push_back('{1'b1, CNT_W'(6), 16'd1});
        tick();
        drive(1'b0, 0, 1'b0);
        check_int("first_start_after_reset", int'(bus.TX_START), 1);
        repeat (19) tick();
        drive(1'b0, 0, 1'b1);
        tick();
        drive(1'b0, 0, 1'b0);
        base = starts_seen;
        repeat (2 * REFRESH_CYC + 50) tick();
        check_int("no_refresh_start", starts_seen - base, 0);
        check_int("refresh_bank_held", int'(bus.DISP_BANK), 1);
        check_int("refresh_frame_cnt", int'(bus.FRAME_CNT), 1);
        check_int("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the bench always ends on its own
    initial begin
        #200000;
        $display("FAIL timeout: got simulation still running, required completion");
        $fatal(1, "timeout");
    end

endmodule
